// File: rtl/seq_matcher_param_if.sv
// Symbol-stream bus for seq_matcher_param: pattern/symbol/strobe in,
// match status and running sum out.
interface seq_matcher_param_if #(
    parameter int SYMBOL_W    = 4,
    parameter int PATTERN_LEN = 4,
    parameter int CNT_W       = 8,
    parameter int SUM_W       = 64
);
    localparam int FILL_W = $clog2(PATTERN_LEN + 1);

    logic [PATTERN_LEN*SYMBOL_W-1:0] pattern;
    logic [SYMBOL_W-1:0]             symbol_in;
    logic                            read;
    logic                            clear;
    logic                            find;
    logic [CNT_W-1:0]                match_count;
    logic [FILL_W-1:0]               fill_level;
    logic [SUM_W-1:0]                addition_result;

    modport master (
        output pattern, symbol_in, read, clear,
        input  find, match_count, fill_level, addition_result
    );

    modport slave (
        input  pattern, symbol_in, read, clear,
        output find, match_count, fill_level, addition_result
    );
endinterface

// File: rtl/seq_matcher_param.sv
// Streaming symbol-sequence matcher with overlap mode and saturating count.
// Define SEQ_MATCHER_SUM_EN to build the running-sum accumulator.
module seq_matcher_param #(
    parameter int SYMBOL_W    = 4,
    parameter int PATTERN_LEN = 4,
    parameter int OVERLAP     = 1,
    parameter int CNT_W       = 8,
    parameter int SUM_W       = 64
) (
    input logic               clock,
    input logic               reset,
    seq_matcher_param_if.slave bus
);
    localparam int WIN_W  = PATTERN_LEN * SYMBOL_W;
    localparam int FILL_W = $clog2(PATTERN_LEN + 1);
    localparam logic [FILL_W-1:0] FULL = FILL_W'(PATTERN_LEN);

    logic              read_q;
    logic [WIN_W-1:0]  win;
    logic [FILL_W-1:0] fill;
    logic              find_q;
    logic [CNT_W-1:0]  cnt;

    logic              accept;
    logic [WIN_W-1:0]  win_nx;
    logic [FILL_W-1:0] fill_nx;
    logic              hit;

    // Oldest symbol sits in the low bits so the window lines up with pattern.
    always_comb begin
        accept  = bus.read & ~read_q;
        win_nx  = {bus.symbol_in, win[WIN_W-1:SYMBOL_W]};
        fill_nx = (fill == FULL) ? FULL : fill + 1'b1;
        hit     = (fill_nx == FULL) && (win_nx == bus.pattern);
    end

    // read_q resets high so a strobe held across reset is not taken.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            read_q <= 1'b1;
            win    <= '0;
            fill   <= '0;
            find_q <= 1'b0;
            cnt    <= '0;
        end else begin
            read_q <= bus.read;
            if (bus.clear) begin
                win    <= '0;
                fill   <= '0;
                find_q <= 1'b0;
                cnt    <= '0;
            end else if (accept) begin
                win    <= win_nx;
                find_q <= hit;
                fill   <= (hit && OVERLAP == 0) ? '0 : fill_nx;
                if (hit && ~&cnt)
                    cnt <= cnt + 1'b1;
            end
        end
    end

    assign bus.find        = find_q;
    assign bus.match_count = cnt;
    assign bus.fill_level  = fill;

`ifdef SEQ_MATCHER_SUM_EN
    logic [SUM_W-1:0] sum;

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            sum <= '0;
        else if (bus.clear)
            sum <= '0;
        else if (accept)
            sum <= sum + SUM_W'(bus.symbol_in);
    end

    assign bus.addition_result = sum;
`else
    assign bus.addition_result = {SUM_W{1'b0}};
`endif
endmodule

// File: tb/tb_seq_matcher_param.sv
// Scoreboard bench for seq_matcher_param: default, non-overlap and
// 2-bit-counter instances share one directed stimulus stream.
module tb_seq_matcher_param;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] pattern;
    logic [3:0]  symbol_in;
    logic        read;
    logic        clear;

    always #5 clock = ~clock;

    seq_matcher_param_if #(.CNT_W(8)) ia ();
    seq_matcher_param_if #(.CNT_W(8)) ib ();
    seq_matcher_param_if #(.CNT_W(2)) ic ();

    assign {ia.pattern, ia.symbol_in, ia.read, ia.clear} =
           {pattern, symbol_in, read, clear};
    assign {ib.pattern, ib.symbol_in, ib.read, ib.clear} =
           {pattern, symbol_in, read, clear};
    assign {ic.pattern, ic.symbol_in, ic.read, ic.clear} =
           {pattern, symbol_in, read, clear};

    seq_matcher_param #(.OVERLAP(1), .CNT_W(8)) dut_a (
        .clock(clock), .reset(reset), .bus(ia)
    );
    seq_matcher_param #(.OVERLAP(0), .CNT_W(8)) dut_b (
        .clock(clock), .reset(reset), .bus(ib)
    );
    seq_matcher_param #(.OVERLAP(1), .CNT_W(2)) dut_c (
        .clock(clock), .reset(reset), .bus(ic)
    );

    typedef struct {
        int     dut;
        string  name;
        int     f;
        int     cnt;
        int     fill;
        longint sum;
    } exp_t;

    exp_t q[$];
    int   nchk = 0;
    int   npass = 0;

    function automatic longint es(input longint v);
`ifdef SEQ_MATCHER_SUM_EN
        return v;
`else
        return 0;
`endif
    endfunction

    task automatic chk(input int d, input string n, input int f,
                       input int c, input int l, input longint s);
        exp_t e;
        e.dut = d; e.name = n; e.f = f;
        e.cnt = c; e.fill = l; e.sum = s;
        q.push_back(e);
    endtask

    task automatic cmp(input string n, input int d, input string fld,
                       input longint act, input longint req);
        if (req >= 0) begin
            nchk++;
            if (act == req) npass++;
            else $display("FAIL %s dut%0d %s got %0d want %0d",
                          n, d, fld, act, req);
        end
    endtask

    // Monitor: drains every pending expectation on the falling edge.
    always @(negedge clock) begin
        while (q.size() > 0) begin
            exp_t   e;
            longint a_f, a_c, a_l, a_s;
            e = q.pop_front();
            a_f = 0; a_c = 0; a_l = 0; a_s = 0;
            case (e.dut)
                0: begin
                    a_f = ia.find;        a_c = ia.match_count;
                    a_l = ia.fill_level;  a_s = ia.addition_result;
                end
                1: begin
                    a_f = ib.find;        a_c = ib.match_count;
                    a_l = ib.fill_level;  a_s = ib.addition_result;
                end
                default: begin
                    a_f = ic.find;        a_c = ic.match_count;
                    a_l = ic.fill_level;  a_s = ic.addition_result;
                end
            endcase
            cmp(e.name, e.dut, "find", a_f, e.f);
            cmp(e.name, e.dut, "count", a_c, e.cnt);
            cmp(e.name, e.dut, "fill", a_l, e.fill);
            cmp(e.name, e.dut, "sum", a_s, e.sum);
        end
    end

    task automatic send(input logic [3:0] s);
        @(negedge clock);
        symbol_in = s;
        read = 1'b1;
        repeat (30) @(negedge clock);
        read = 1'b0;
        repeat (30) @(negedge clock);
    endtask

    task automatic do_clear();
        @(negedge clock);
        clear = 1'b1;
        @(negedge clock);
        clear = 1'b0;
        @(negedge clock);
    endtask

    logic [3:0] ref_s [14] = '{0, 2, 15, 2, 3, 5, 9, 0, 2, 1, 1, 2, 3, 4};
    int a_c [9] = '{0, 0, 0, 1, 2, 3, 4, 5, 6};
    int b_f [9] = '{0, 0, 0, 1, 0, 0, 0, 1, 0};
    int b_c [9] = '{0, 0, 0, 1, 1, 1, 1, 2, 2};
    int b_l [9] = '{1, 2, 3, 0, 1, 2, 3, 0, 1};
    int c_c [9] = '{0, 0, 0, 1, 2, 3, 3, 3, 3};

    initial begin
        pattern = 16'h4321;
        symbol_in = '0;
        read = 1'b0;
        clear = 1'b0;
        repeat (3) @(negedge clock);
        for (int d = 0; d < 3; d++) chk(d, "reset", 0, 0, 0, 0);
        @(negedge clock);
        reset = 1'b0;

        for (int i = 0; i < 14; i++) begin
            send(ref_s[i]);
            chk(0, "ref_find", (i == 13) ? 1 : 0, -1, -1, -1);
        end
        chk(0, "ref_end", 1, 1, 4, es(49));
        chk(1, "ref_noovl", 1, 1, 0, es(49));
        chk(2, "ref_sat", 1, 1, 4, -1);

        do_clear();
        for (int d = 0; d < 3; d++) chk(d, "clear", 0, 0, 0, 0);

        @(negedge clock);
        symbol_in = 4'd5;
        read = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clock);
            symbol_in = 4'(i + 6);
        end
        read = 1'b0;
        repeat (30) @(negedge clock);
        chk(0, "held", 0, 0, 1, es(5));
        do_clear();

        pattern = 16'h1111;
        for (int k = 0; k < 9; k++) begin
            send(4'd1);
            chk(0, "ovl", (k >= 3) ? 1 : 0, a_c[k],
                (k >= 3) ? 4 : k + 1, es(k + 1));
            chk(1, "noovl", b_f[k], b_c[k], b_l[k], es(k + 1));
            chk(2, "sat", (k >= 3) ? 1 : 0, c_c[k], -1, -1);
        end

        pattern = 16'h4321;
        send(4'd1);
        send(4'd2);
        send(4'd3);
        chk(0, "pre_rst", 0, 6, 4, es(15));

        @(posedge clock);
        #1;
        symbol_in = 4'd4;
        read = 1'b1;
        reset = 1'b1;
        for (int d = 0; d < 3; d++) chk(d, "rst_async", 0, 0, 0, 0);
        @(negedge clock);
        #1;
        reset = 1'b0;
        repeat (30) @(negedge clock);
        chk(0, "rst_noacc", 0, 0, 0, 0);
        read = 1'b0;
        repeat (30) @(negedge clock);
        send(4'd4);
        chk(0, "rst_after", 0, 0, 1, es(4));

        do_clear();
        send(4'd1);
        send(4'd2);
        send(4'd3);
        chk(0, "pre_clr", 0, 0, 3, es(6));
        @(negedge clock);
        symbol_in = 4'd4;
        read = 1'b1;
        clear = 1'b1;
        @(negedge clock);
        clear = 1'b0;
        repeat (29) @(negedge clock);
        read = 1'b0;
        repeat (30) @(negedge clock);
        chk(0, "clr_coll", 0, 0, 0, 0);
        send(4'd4);
        chk(0, "clr_after", 0, 0, 1, es(4));

        repeat (3) @(negedge clock);
        nchk++;
        if (q.size() == 0) npass++;
        else $display("FAIL drain pending got %0d want 0", q.size());

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end
endmodule
